i2c_bus_arbiter: RTL and testbench
==================================

# i2c_bus_arbiter

Two-requester arbiter that shares one I2C driver between the PCF8563 RTC controller and the PCF8591 AD/DA controller, so both devices can use a single I2C master. It sits between the two `*_ctrl`-style requesters and the driver's `i2c_exec` / `i2c_done` handshake. Each command is latched, granted round-robin, forwarded with the owning requester's slave address, and the result is routed back to the owner only.

## Interface
Parameters:
- `R0_SLAVE_ADDR`, default 7'h51: slave address driven while requester 0 (RTC) owns the bus.
- `R1_SLAVE_ADDR`, default 7'h48: slave address driven while requester 1 (PCF8591) owns the bus.
- `TIMEOUT_CYC`, default 100000: watchdog limit in `sys_clk` cycles. Used only when `I2C_ARB_TIMEOUT_EN` is defined.

Ports:
- `sys_clk` in 1: single clock, the driver operation clock (`dri_clk`).
- `sys_rst` in 1: asynchronous, active-high reset.
- `s_exec[1:0]` in 2: per-requester command pulse, one cycle wide.
- `s_rh_wl[1:0]` in 2: per-requester read (1) / write (0).
- `s_bit_ctrl[1:0]` in 2: per-requester word-address width, 1 = 16 bit.
- `s0_addr`, `s1_addr` in 16 each: word address.
- `s0_data_w`, `s1_data_w` in 8 each: write data.
- `s_done[1:0]` out 2: per-requester completion pulse, one cycle wide.
- `s_ack` out 1: ack status of the last completion. 0 = acked, 1 = nack or timeout.
- `s_data_r` out 8: read data of the last completion.
- `s_ovr[1:0]` out 2: one-cycle pulse when a command is dropped.
- `m_exec` out 1: command pulse to the driver.
- `m_dev_addr` out 7: slave address to the driver.
- `m_rh_wl` out 1, `m_bit_ctrl` out 1, `m_addr` out 16, `m_data_w` out 8: command fields to the driver.
- `m_done` in 1, `m_ack` in 1, `m_data_r` in 8: driver completion and result.
- `busy` out 1: high in every state except IDLE.

## Operation
- Per-requester pending latch:
  - `s_exec[i]` sets `pend[i]` and captures that requester's command fields into a holding register.
  - `pend[i]` clears when requester i is granted.
- Overrun: if `s_exec[i]` arrives while `pend[i]` is set, or while requester i is in service, the command is dropped. `s_ovr[i]` pulses and the held command is kept unchanged.
- State machine:
  - IDLE → ISSUE when any `pend` is set.
  - ISSUE → WAIT after one cycle.
  - WAIT → RESP on `m_done`.
  - RESP → IDLE after one cycle.
  - With `I2C_ARB_TIMEOUT_EN` only: WAIT → FLUSH on timeout, and FLUSH → IDLE on `m_done` or after a second `TIMEOUT_CYC` cycles.
- Round-robin arbitration:
  - A `last` pointer records the most recently granted requester.
  - When both are pending, the requester ≠ `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- Grant (IDLE → ISSUE transition):
  - `owner` is set.
  - `m_dev_addr` and all `m_*` command fields load from the owner's holding register.
  - These fields stay stable until the transaction leaves WAIT (into RESP, or into FLUSH when the timeout is compiled in).
- `m_exec` is high only in ISSUE, for exactly one cycle.
- On `m_done` in WAIT:
  - `m_ack` and `m_data_r` are registered into `s_ack` and `s_data_r`.
  - `s_done[owner]` pulses in RESP.
  - `s_ack` and `s_data_r` hold until the next completion.
- `m_done` seen outside WAIT/FLUSH is ignored.
- Reset, including mid-transaction:
  - All state returns to IDLE; pending latches and `last` clear/reset.
  - All outputs go to 0 except `m_dev_addr`, which resets to `R0_SLAVE_ADDR`.
  - No `s_done` is issued for an aborted transaction.

## Timing
- Request to driver: `s_exec` high in cycle N → `pend` set at the edge ending N → `m_exec` high in cycle N+2, when the bus is idle.
- Driver to requester: `m_done` high in cycle M → `s_done` high in cycle M+1, with `s_ack` and `s_data_r` valid in that same cycle.
- Back-to-back: the next grant can issue in the cycle after RESP, so the minimum gap between consecutive `m_exec` pulses is 3 cycles plus the driver latency.
- Simultaneous `s_exec[0]` and `s_exec[1]` with the bus idle: the winner is chosen by `last`, and the loser is served immediately after.
- A new `s_exec[i]` in the same cycle as `s_done[i]` is accepted, because service has ended.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYC+1)` runs in WAIT.
  - On expiry, `s_done[owner]` pulses with `s_ack=1` and `s_data_r=8'h00`, then the FSM enters FLUSH.
  - In FLUSH, `busy=1` and no new grant is issued.
- `I2C_ARB_TIMEOUT_EN` undefined: there is no counter, WAIT waits indefinitely for `m_done`, and the FLUSH state does not exist.

## Structure
- Shared package `i2c_arb_pkg` holds:
  - the state encodings (IDLE, ISSUE, WAIT, RESP, FLUSH);
  - the requester count (2);
  - the command-record field widths: 16-bit address, 8-bit data, 7-bit device address.
- One sub-module, `i2c_arb_rr`, is natural: a combinational 2-way round-robin picker plus the registered `last` pointer.

## Test plan
- Single read: requester 1 read at `s1_addr=16'h0003`; driver returns `m_data_r=8'hA5`, `m_ack=0` → `m_dev_addr=7'h48`, `m_exec` 2 cycles after `s_exec`, `s_done=2'b10`, `s_data_r=8'hA5`.
- Tie: both requesters pulse `s_exec` in the same cycle after reset → requester 0 is served first with `m_dev_addr=7'h51`; requester 1 is served next; `s_done` is 2'b01 then 2'b10.
- Overrun: a second `s_exec[0]` while requester 0 is in WAIT → `s_ovr=2'b01` for one cycle, and only one `m_exec` is issued for requester 0.
- Nack passthrough: driver returns `m_ack=1` → `s_ack=1` and `s_done` reaches the owner only.
- Reset in WAIT: assert `sys_rst` → `busy=0`, `m_exec=0`, no `s_done`; a fresh request after reset is served normally.
- Timeout (with `I2C_ARB_TIMEOUT_EN`, `TIMEOUT_CYC=50`): no `m_done` → `s_done` at cycle 51 of WAIT with `s_ack=1` and `s_data_r=0`; `busy` stays high in FLUSH until `m_done` arrives.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-requester I2C bus arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package i2c_arb_pkg;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;
   localparam int DEV_W   = 7;

   // FSM encodings; ST_FLUSH is only reachable when the watchdog is compiled in
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;

   // One latched requester command
   typedef struct packed {
      logic              rh_wl;
      logic              bit_ctrl;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data_w;
   } cmd_t;

endpackage

// File: rtl/i2c_arb_rr.sv
// Two-way round-robin picker with a registered last-grant pointer.
// Latency: pick is combinational; the pointer updates on the edge where the grant is taken.
// Backpressure: none; a pick only takes effect when the caller asserts i_take.
module i2c_arb_rr (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_any,
   output logic       o_idx
);

   logic r_last;
   logic w_idx;

   // On a tie the requester that was not granted last wins; otherwise the sole requester wins
   always_comb begin
      w_idx = 1'b0;
      if (i_req == 2'b11) begin
         w_idx = ~r_last;
      end else if (i_req[1]) begin
         w_idx = 1'b1;
      end
   end

   assign o_idx = w_idx;
   assign o_any = |i_req;

   // Pointer starts at 1 so requester 0 wins the first tie
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last <= 1'b1;
      end else if (i_take) begin
         r_last <= w_idx;
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C driver between two requesters (RTC, AD/DA); optional watchdog via I2C_ARB_TIMEOUT_EN.
// Latency: s_exec to m_exec 2 cycles when idle; m_done to s_done 1 cycle.
// Backpressure: one pending command per requester; a new s_exec while pending or in service is dropped with s_ovr.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter logic [DEV_W-1:0] R0_SLAVE_ADDR = 7'h51,
   parameter logic [DEV_W-1:0] R1_SLAVE_ADDR = 7'h48,
   parameter int               TIMEOUT_CYC   = 100000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [1:0]        s_exec,
   input  logic [1:0]        s_rh_wl,
   input  logic [1:0]        s_bit_ctrl,
   input  logic [ADDR_W-1:0] s0_addr,
   input  logic [ADDR_W-1:0] s1_addr,
   input  logic [DATA_W-1:0] s0_data_w,
   input  logic [DATA_W-1:0] s1_data_w,
   output logic [1:0]        s_done,
   output logic              s_ack,
   output logic [DATA_W-1:0] s_data_r,
   output logic [1:0]        s_ovr,
   output logic              m_exec,
   output logic [DEV_W-1:0]  m_dev_addr,
   output logic              m_rh_wl,
   output logic              m_bit_ctrl,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_data_w,
   input  logic              m_done,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_data_r,
   output logic              busy
);

   logic [2:0]              r_state;
   logic [1:0]              r_pend;
   cmd_t [NUM_REQ-1:0]      r_hold;
   logic                    r_owner;
   logic [1:0]              r_ovr;
   logic [1:0]              r_done;
   logic                    r_ack;
   logic [DATA_W-1:0]       r_data_r;
   logic [DEV_W-1:0]        r_dev;
   cmd_t                    r_mcmd;

   logic                    w_any;
   logic                    w_idx;
   logic                    w_grant;
   logic                    w_done_ok;
   logic                    w_tmo;
   logic                    w_flush_end;
   logic [1:0]              w_insvc;
   logic [1:0]              w_busy_req;
   logic [1:0]              w_owner_oh;
   cmd_t [NUM_REQ-1:0]      w_cmd_in;

   assign w_cmd_in[0] = '{rh_wl: s_rh_wl[0], bit_ctrl: s_bit_ctrl[0], addr: s0_addr, data_w: s0_data_w};
   assign w_cmd_in[1] = '{rh_wl: s_rh_wl[1], bit_ctrl: s_bit_ctrl[1], addr: s1_addr, data_w: s1_data_w};

   // Service ends when the result is handed back, so RESP/FLUSH do not block a new command
   assign w_owner_oh = {r_owner, ~r_owner};
   assign w_insvc    = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) ? w_owner_oh : 2'b00;
   assign w_busy_req = r_pend | w_insvc;
   assign w_grant    = (r_state == ST_IDLE) && w_any;
   assign w_done_ok  = (r_state == ST_WAIT) && m_done;

   i2c_arb_rr u_rr (
      .i_clk  (sys_clk),
      .i_rst  (sys_rst),
      .i_req  (r_pend),
      .i_take (w_grant),
      .o_any  (w_any),
      .o_idx  (w_idx)
   );

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_cnt;

   assign w_tmo       = (r_state == ST_WAIT) && !m_done && (r_cnt == CNT_LAST);
   assign w_flush_end = (r_state == ST_FLUSH) && (m_done || (r_cnt == CNT_LAST));

   // Watchdog counts WAIT cycles, then restarts to bound the FLUSH drain
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_cnt <= '0;
      end else if ((r_state == ST_ISSUE) || w_tmo) begin
         r_cnt <= '0;
      end else if ((r_state == ST_WAIT) || (r_state == ST_FLUSH)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_tmo       = 1'b0;
   assign w_flush_end = 1'b0;
`endif

   // Pending latches: capture on an accepted pulse, clear on grant
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_pend <= 2'b00;
         r_hold <= '0;
         r_ovr  <= 2'b00;
      end else begin
         r_ovr <= s_exec & w_busy_req;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (s_exec[i] && !w_busy_req[i]) begin
               r_pend[i] <= 1'b1;
               r_hold[i] <= w_cmd_in[i];
            end else if (w_grant && (w_idx == 1'(i))) begin
               r_pend[i] <= 1'b0;
            end
         end
      end
   end

   // Transaction sequencer
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_any) r_state <= ST_ISSUE;
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (m_done)     r_state <= ST_RESP;
               else if (w_tmo) r_state <= ST_FLUSH;
            end
            ST_RESP:  r_state <= ST_IDLE;
            ST_FLUSH: if (w_flush_end) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Grant loads the owner's command; it stays untouched until the next grant
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_owner <= 1'b0;
         r_dev   <= R0_SLAVE_ADDR;
         r_mcmd  <= '0;
      end else if (w_grant) begin
         r_owner <= w_idx;
         r_dev   <= w_idx ? R1_SLAVE_ADDR : R0_SLAVE_ADDR;
         r_mcmd  <= r_hold[w_idx];
      end
   end

   // Result capture and owner-only completion pulse (normal finish or watchdog expiry)
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_done   <= 2'b00;
         r_ack    <= 1'b0;
         r_data_r <= '0;
      end else if (w_done_ok) begin
         r_done   <= w_owner_oh;
         r_ack    <= m_ack;
         r_data_r <= m_data_r;
      end else if (w_tmo) begin
         r_done   <= w_owner_oh;
         r_ack    <= 1'b1;
         r_data_r <= '0;
      end else begin
         r_done   <= 2'b00;
      end
   end

   assign s_done     = r_done;
   assign s_ack      = r_ack;
   assign s_data_r   = r_data_r;
   assign s_ovr      = r_ovr;
   assign m_exec     = (r_state == ST_ISSUE);
   assign m_dev_addr = r_dev;
   assign m_rh_wl    = r_mcmd.rh_wl;
   assign m_bit_ctrl = r_mcmd.bit_ctrl;
   assign m_addr     = r_mcmd.addr;
   assign m_data_w   = r_mcmd.data_w;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter; plays both requesters and the I2C driver.
// Latency: checks the 2-cycle request path and the 1-cycle completion path.
// Backpressure: exercises overrun drop, tie arbitration and accept-on-done.
module tb_i2c_bus_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [1:0]  s_exec = '0, s_rh_wl = '0, s_bit_ctrl = '0;
   logic [15:0] s0_addr = '0, s1_addr = '0;
   logic [7:0]  s0_data_w = '0, s1_data_w = '0;
   logic [1:0]  s_done, s_ovr;
   logic        s_ack;
   logic [7:0]  s_data_r;
   logic        m_exec, m_rh_wl, m_bit_ctrl, busy;
   logic [6:0]  m_dev_addr;
   logic [15:0] m_addr;
   logic [7:0]  m_data_w;
   logic        m_done = 1'b0, m_ack = 1'b0;
   logic [7:0]  m_data_r = '0;

   int n_vec = 0;
   int n_err = 0;

   always #5 sys_clk = ~sys_clk;

   i2c_bus_arbiter #(
      .R0_SLAVE_ADDR (7'h51),
      .R1_SLAVE_ADDR (7'h48),
      .TIMEOUT_CYC   (50)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .s_exec     (s_exec),
      .s_rh_wl    (s_rh_wl),
      .s_bit_ctrl (s_bit_ctrl),
      .s0_addr    (s0_addr),
      .s1_addr    (s1_addr),
      .s0_data_w  (s0_data_w),
      .s1_data_w  (s1_data_w),
      .s_done     (s_done),
      .s_ack      (s_ack),
      .s_data_r   (s_data_r),
      .s_ovr      (s_ovr),
      .m_exec     (m_exec),
      .m_dev_addr (m_dev_addr),
      .m_rh_wl    (m_rh_wl),
      .m_bit_ctrl (m_bit_ctrl),
      .m_addr     (m_addr),
      .m_data_w   (m_data_w),
      .m_done     (m_done),
      .m_ack      (m_ack),
      .m_data_r   (m_data_r),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      // ---- reset state
      tick(); tick();
      chk("rst_busy",   busy, 0);
      chk("rst_mexec",  m_exec, 0);
      chk("rst_sdone",  s_done, 0);
      chk("rst_dev",    m_dev_addr, 7'h51);
      chk("rst_ack",    s_ack, 0);
      chk("rst_datar",  s_data_r, 0);
      chk("rst_ovr",    s_ovr, 0);
      sys_rst = 1'b0;
      tick();

      // ---- tie: both pulse together, requester 0 first
      s0_addr = 16'h0010; s0_data_w = 8'h3C; s1_addr = 16'h0005;
      s_rh_wl = 2'b10; s_bit_ctrl = 2'b01;
      s_exec = 2'b11; tick(); s_exec = 2'b00;
      chk("tie_n1_mexec", m_exec, 0);
      tick();
      chk("tie0_mexec", m_exec, 1);
      chk("tie0_dev",   m_dev_addr, 7'h51);
      chk("tie0_addr",  m_addr, 16'h0010);
      chk("tie0_dw",    m_data_w, 8'h3C);
      chk("tie0_rh",    m_rh_wl, 0);
      chk("tie0_bc",    m_bit_ctrl, 1);
      tick();
      chk("tie0_wait_mexec", m_exec, 0);
      chk("tie0_wait_busy",  busy, 1);
      m_done = 1'b1; m_ack = 1'b0; m_data_r = 8'h11; tick(); m_done = 1'b0;
      chk("tie0_sdone", s_done, 2'b01);
      chk("tie0_datar", s_data_r, 8'h11);
      chk("tie_ovr",    s_ovr, 0);
      tick();
      chk("tie_gap_sdone", s_done, 0);
      tick();
      chk("tie1_mexec", m_exec, 1);
      chk("tie1_dev",   m_dev_addr, 7'h48);
      chk("tie1_addr",  m_addr, 16'h0005);
      chk("tie1_rh",    m_rh_wl, 1);
      chk("tie1_bc",    m_bit_ctrl, 0);
      tick();
      m_done = 1'b1; m_data_r = 8'h5A; tick(); m_done = 1'b0;
      chk("tie1_sdone", s_done, 2'b10);
      chk("tie1_datar", s_data_r, 8'h5A);
      tick();

      // ---- single read by requester 1
      s1_addr = 16'h0003; s_rh_wl = 2'b10; s_bit_ctrl = 2'b00;
      s_exec = 2'b10; tick(); s_exec = 2'b00;
      chk("rd_n1_mexec", m_exec, 0);
      tick();
      chk("rd_mexec", m_exec, 1);
      chk("rd_dev",   m_dev_addr, 7'h48);
      chk("rd_addr",  m_addr, 16'h0003);
      tick();
      m_done = 1'b1; m_ack = 1'b0; m_data_r = 8'hA5; tick(); m_done = 1'b0;
      chk("rd_sdone", s_done, 2'b10);
      chk("rd_datar", s_data_r, 8'hA5);
      chk("rd_ack",   s_ack, 0);
      tick();
      chk("rd_after_sdone", s_done, 0);
      chk("rd_after_busy",  busy, 0);
      chk("rd_hold_datar",  s_data_r, 8'hA5);

      // ---- stray m_done while idle is ignored
      m_done = 1'b1; m_data_r = 8'hEE; tick(); m_done = 1'b0;
      chk("stray_sdone", s_done, 0);
      chk("stray_datar", s_data_r, 8'hA5);
      chk("stray_busy",  busy, 0);

      // ---- overrun: second pulse from requester 0 while in WAIT
      s0_addr = 16'h0020; s_rh_wl = 2'b01;
      s_exec = 2'b01; tick(); s_exec = 2'b00;
      tick();
      chk("ovr_mexec", m_exec, 1);
      chk("ovr_addr",  m_addr, 16'h0020);
      tick();
      s0_addr = 16'h0099; s_exec = 2'b01; tick(); s_exec = 2'b00;
      chk("ovr_pulse",     s_ovr, 2'b01);
      chk("ovr_addr_hold", m_addr, 16'h0020);
      chk("ovr_no_mexec",  m_exec, 0);
      tick();
      chk("ovr_pulse_end", s_ovr, 2'b00);
      m_done = 1'b1; m_data_r = 8'h42; tick(); m_done = 1'b0;
      chk("ovr_sdone", s_done, 2'b01);
      tick(); tick();
      chk("ovr_no_regrant", m_exec, 0);
      chk("ovr_idle",       busy, 0);

      // ---- nack passthrough, then new pulse in the s_done cycle is accepted
      s0_addr = 16'h0030; s0_data_w = 8'hE1; s_rh_wl = 2'b00;
      s_exec = 2'b01; tick(); s_exec = 2'b00;
      tick();
      chk("nack_mexec", m_exec, 1);
      chk("nack_dw",    m_data_w, 8'hE1);
      tick();
      m_done = 1'b1; m_ack = 1'b1; m_data_r = 8'h77; tick(); m_done = 1'b0; m_ack = 1'b0;
      chk("nack_sdone", s_done, 2'b01);
      chk("nack_ack",   s_ack, 1);
      s0_addr = 16'h0040; s_exec = 2'b01; tick(); s_exec = 2'b00;
      chk("acc_ovr",     s_ovr, 0);
      chk("acc_sdone",   s_done, 0);
      chk("acc_ackhold", s_ack, 1);
      tick();
      chk("acc_mexec", m_exec, 1);
      chk("acc_addr",  m_addr, 16'h0040);
      tick();
      chk("acc_wait_busy", busy, 1);

      // ---- reset in WAIT
      #2 sys_rst = 1'b1; m_done = 1'b1;
      #1;
      chk("rstw_busy",  busy, 0);
      chk("rstw_mexec", m_exec, 0);
      chk("rstw_sdone", s_done, 0);
      chk("rstw_dev",   m_dev_addr, 7'h51);
      chk("rstw_ack",   s_ack, 0);
      chk("rstw_addr",  m_addr, 0);
      tick();
      sys_rst = 1'b0; m_done = 1'b0;
      tick();
      chk("rstw_after_sdone", s_done, 0);
      chk("rstw_after_busy",  busy, 0);

      // ---- fresh request after reset
      s1_addr = 16'h0007; s_rh_wl = 2'b10;
      s_exec = 2'b10; tick(); s_exec = 2'b00;
      tick();
      chk("post_mexec", m_exec, 1);
      chk("post_dev",   m_dev_addr, 7'h48);
      chk("post_addr",  m_addr, 16'h0007);
      tick();
      m_done = 1'b1; m_data_r = 8'hC3; tick(); m_done = 1'b0;
      chk("post_sdone", s_done, 2'b10);
      chk("post_datar", s_data_r, 8'hC3);
      tick();

`ifdef I2C_ARB_TIMEOUT_EN
      // ---- watchdog: no m_done, s_done in WAIT cycle 51, then FLUSH until m_done
      s0_addr = 16'h0050; s_rh_wl = 2'b01;
      s_exec = 2'b01; tick(); s_exec = 2'b00;
      tick();
      chk("tmo_mexec", m_exec, 1);
      tick();
      for (int k = 0; k < 49; k++) tick();
      chk("tmo_w50_sdone", s_done, 0);
      chk("tmo_w50_busy",  busy, 1);
      tick();
      chk("tmo_sdone", s_done, 2'b01);
      chk("tmo_ack",   s_ack, 1);
      chk("tmo_datar", s_data_r, 0);
      chk("tmo_busy",  busy, 1);
      tick(); tick();
      chk("flush_busy",  busy, 1);
      chk("flush_mexec", m_exec, 0);
      chk("flush_sdone", s_done, 0);
      m_done = 1'b1; tick(); m_done = 1'b0;
      chk("flush_end_busy",  busy, 0);
      chk("flush_end_sdone", s_done, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
